// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: validates PS/2 receiver frames, folds scan-code set 2
// E0/F0 prefixes into single key events and queues them in a small FIFO.
// Optional feature macro: PS2_KEYSEQ_PARITY_CHECK_EN (odd-parity checking).
module ps2_key_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_done,
    input  logic [9:0] frame,
    output logic       rx_resync,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       err_frame,
    output logic       err_parity,
    output logic       err_timeout,
    output logic       fifo_ovf
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EW = 10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_frame_done_q;
    logic [TW-1:0]    r_tmo;
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             r_key_valid;
    logic [7:0]       r_key_code;
    logic             r_key_ext;
    logic             r_key_break;
    logic             r_err_frame;
    logic             r_err_parity;
    logic             r_err_timeout;
    logic             r_fifo_ovf;
    logic             r_rx_resync;

    logic             w_accept;
    logic [7:0]       w_byte;
    logic             w_is_e0;
    logic             w_is_f0;
    logic             w_start_err;
    logic             w_par_err;
    logic             w_byte_ok;
    logic             w_push_req;
    logic [EW-1:0]    w_push_data;
    logic             w_full;
    logic             w_pop;
    logic             w_do_push;
    logic             w_ovf;
    logic [CW-1:0]    w_cnt_after_pop;
    logic [CW-1:0]    w_cnt_next;
    logic [AW-1:0]    w_rd_next;
    logic [EW-1:0]    w_head_next;

    // Frame decode: rising edge of frame_done, start bit and parity checks
    assign w_accept    = frame_done && !r_frame_done_q;
    assign w_byte      = frame[8:1];
    assign w_is_e0     = (w_byte == 8'hE0);
    assign w_is_f0     = (w_byte == 8'hF0);
    assign w_start_err = frame[0];
`ifdef PS2_KEYSEQ_PARITY_CHECK_EN
    assign w_par_err   = ~(^frame[9:1]);
`else
    logic w_unused_parity;
    assign w_unused_parity = frame[9];
    assign w_par_err   = 1'b0;
`endif
    assign w_byte_ok   = w_accept && !w_start_err && !w_par_err;

    // Any non-prefix byte that passed the checks becomes an event
    assign w_push_req  = w_byte_ok && !w_is_e0 && !w_is_f0;
    assign w_push_data = {w_byte,
                          (r_state == S_EXT) || (r_state == S_EXT_BRK),
                          (r_state == S_BRK) || (r_state == S_EXT_BRK)};

    // FIFO bookkeeping; a pop frees a slot for a same-cycle push when full
    assign w_full          = (r_count == CW'(FIFO_DEPTH));
    assign w_pop           = key_ready && (r_count != '0);
    assign w_do_push       = w_push_req && (!w_full || w_pop);
    assign w_ovf           = w_push_req && w_full && !w_pop;
    assign w_cnt_after_pop = r_count - CW'(w_pop);
    assign w_cnt_next      = w_cnt_after_pop + CW'(w_do_push);
    assign w_rd_next       = r_rd_ptr + AW'(w_pop);
    assign w_head_next     = (w_do_push && (w_cnt_after_pop == '0)) ? w_push_data
                                                                     : r_mem[w_rd_next];

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Sequencer FSM, timeout counter, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_frame_done_q <= 1'b0;
            r_tmo          <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_key_valid    <= 1'b0;
            r_key_code     <= 8'h00;
            r_key_ext      <= 1'b0;
            r_key_break    <= 1'b0;
            r_err_frame    <= 1'b0;
            r_err_parity   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_fifo_ovf     <= 1'b0;
            r_rx_resync    <= 1'b0;
        end else begin
            r_frame_done_q <= frame_done;
            r_err_frame    <= 1'b0;
            r_err_parity   <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_rx_resync    <= 1'b0;
            r_fifo_ovf     <= w_ovf;

            if (w_accept) begin
                r_tmo <= '0;
                if (w_start_err) begin
                    r_err_frame <= 1'b1;
                    r_rx_resync <= 1'b1;
                    r_state     <= S_IDLE;
                end else if (w_par_err) begin
                    r_err_parity <= 1'b1;
                    r_rx_resync  <= 1'b1;
                    r_state      <= S_IDLE;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (w_is_e0)      r_state <= S_EXT;
                            else if (w_is_f0) r_state <= S_BRK;
                            else              r_state <= S_IDLE;
                        end
                        S_EXT: begin
                            if (w_is_f0)      r_state <= S_EXT_BRK;
                            else if (w_is_e0) r_state <= S_EXT;
                            else              r_state <= S_IDLE;
                        end
                        default: begin
                            // A second prefix after F0 is an illegal sequence
                            if (w_is_e0 || w_is_f0) begin
                                r_err_frame <= 1'b1;
                                r_rx_resync <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end
                    endcase
                end
            end else if (r_state != S_IDLE) begin
                if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_err_timeout <= 1'b1;
                    r_rx_resync   <= 1'b1;
                    r_state       <= S_IDLE;
                    r_tmo         <= '0;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
            end else begin
                r_tmo <= '0;
            end

            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_cnt_next;
            r_key_valid <= (w_cnt_next != '0);
            if (w_cnt_next != '0) begin
                r_key_code  <= w_head_next[9:2];
                r_key_ext   <= w_head_next[1];
                r_key_break <= w_head_next[0];
            end else begin
                r_key_code  <= 8'h00;
                r_key_ext   <= 1'b0;
                r_key_break <= 1'b0;
            end
        end
    end

    assign key_valid   = r_key_valid;
    assign key_code    = r_key_code;
    assign key_ext     = r_key_ext;
    assign key_break   = r_key_break;
    assign err_frame   = r_err_frame;
    assign err_parity  = r_err_parity;
    assign err_timeout = r_err_timeout;
    assign fifo_ovf    = r_fifo_ovf;
    assign rx_resync   = r_rx_resync;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed testbench for ps2_key_sequencer (FIFO_DEPTH=4, TIMEOUT_CYCLES=100).
module tb_ps2_key_sequencer;

    logic       clk;
    logic       rst;
    logic       frame_done;
    logic [9:0] frame;
    logic       rx_resync;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       err_frame;
    logic       err_parity;
    logic       err_timeout;
    logic       fifo_ovf;

    int checks   = 0;
    int failures = 0;

    ps2_key_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_done),
        .frame       (frame),
        .rx_resync   (rx_resync),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .err_frame   (err_frame),
        .err_parity  (err_parity),
        .err_timeout (err_timeout),
        .fifo_ovf    (fifo_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build a frame: start bit, data LSB first, odd parity (optionally corrupted)
    function automatic logic [9:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                            input logic bad_start);
        logic par;
        par = ~(^b) ^ bad_par;
        return {par, b, bad_start};
    endfunction

    // One idle cycle with frame_done low, then a one-cycle accept; returns at T+1
    task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_start);
        tick();
        frame      = mk_frame(b, bad_par, bad_start);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic pop();
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        frame_done = 1'b0;
        frame      = 10'h000;
        key_ready  = 1'b0;
        tick();
        tick();
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_resync", rx_resync, 0);
        check("rst_errs", {err_frame, err_parity, err_timeout, fifo_ovf}, 0);
        rst = 1'b1;
        tick();

        // Plain make code
        send(8'h1C, 1'b0, 1'b0);
        check("make_valid", key_valid, 1);
        check("make_code", key_code, 32'h1C);
        check("make_ext", key_ext, 0);
        check("make_brk", key_break, 0);
        check("make_resync", rx_resync, 0);
        pop();
        check("make_popped", key_valid, 0);

        // Extended release E0 F0 75
        send(8'hE0, 1'b0, 1'b0);
        check("e0_noevt", key_valid, 0);
        send(8'hF0, 1'b0, 1'b0);
        check("f0_noevt", key_valid, 0);
        send(8'h75, 1'b0, 1'b0);
        check("extbrk_valid", key_valid, 1);
        check("extbrk_code", key_code, 32'h75);
        check("extbrk_ext", key_ext, 1);
        check("extbrk_brk", key_break, 1);
        pop();
        check("extbrk_single", key_valid, 0);

        // Parity corruption
        send(8'h1C, 1'b1, 1'b0);
`ifdef PS2_KEYSEQ_PARITY_CHECK_EN
        check("par_err", err_parity, 1);
        check("par_resync", rx_resync, 1);
        check("par_noevt", key_valid, 0);
        tick();
        check("par_err_1cyc", err_parity, 0);
        check("par_resync_1cyc", rx_resync, 0);
`else
        check("par_ign_err", err_parity, 0);
        check("par_ign_resync", rx_resync, 0);
        check("par_ign_valid", key_valid, 1);
        check("par_ign_code", key_code, 32'h1C);
        pop();
`endif

        // Start bit error
        send(8'h1C, 1'b0, 1'b1);
        check("start_err", err_frame, 1);
        check("start_resync", rx_resync, 1);
        check("start_noevt", key_valid, 0);
        tick();
        check("start_err_1cyc", err_frame, 0);

        // Prefix after F0 is illegal
        send(8'hF0, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0);
        check("brk_e0_err", err_frame, 1);
        check("brk_e0_noevt", key_valid, 0);

        // Timeout after F0: counter hits 99 in cycle T+100, pulse in T+101
        send(8'hF0, 1'b0, 1'b0);
        repeat (99) tick();
        check("tmo_early", err_timeout, 0);
        tick();
        check("tmo_pulse", err_timeout, 1);
        check("tmo_resync", rx_resync, 1);
        tick();
        check("tmo_1cyc", err_timeout, 0);
        check("tmo_resync_1cyc", rx_resync, 0);
        send(8'h1C, 1'b0, 1'b0);
        check("tmo_after_code", key_code, 32'h1C);
        check("tmo_after_brk", key_break, 0);
        check("tmo_after_ext", key_ext, 0);
        pop();

        // Fill FIFO and overflow
        send(8'h15, 1'b0, 1'b0);
        send(8'h16, 1'b0, 1'b0);
        send(8'h1A, 1'b0, 1'b0);
        send(8'h1B, 1'b0, 1'b0);
        check("fill_no_ovf", fifo_ovf, 0);
        send(8'h1C, 1'b0, 1'b0);
        check("ovf_pulse", fifo_ovf, 1);
        check("ovf_head", key_code, 32'h15);
        tick();
        check("ovf_1cyc", fifo_ovf, 0);

        // Push and pop together while full
        frame      = mk_frame(8'h21, 1'b0, 1'b0);
        frame_done = 1'b1;
        key_ready  = 1'b1;
        tick();
        frame_done = 1'b0;
        key_ready  = 1'b0;
        check("pp_no_ovf", fifo_ovf, 0);
        check("pp_head", key_code, 32'h16);
        pop();
        check("drain_1a", key_code, 32'h1A);
        pop();
        check("drain_1b", key_code, 32'h1B);
        pop();
        check("drain_21", key_code, 32'h21);
        pop();
        check("drain_empty", key_valid, 0);

        // Reset mid-sequence with events queued
        send(8'h15, 1'b0, 1'b0);
        send(8'h16, 1'b0, 1'b0);
        send(8'hE0, 1'b0, 1'b0);
        check("pre_rst_valid", key_valid, 1);
        rst = 1'b0;
        tick();
        check("midrst_valid", key_valid, 0);
        check("midrst_code", key_code, 0);
        rst = 1'b1;
        send(8'h75, 1'b0, 1'b0);
        check("post_rst_code", key_code, 32'h75);
        check("post_rst_ext", key_ext, 0);
        pop();
        check("post_rst_empty", key_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
